qoi_stream_sequencer: RTL and testbench

Frame-level controller for the QOI encoder. It emits the 14-byte QOI header, then takes pixels over a valid/ready handshake. For each pixel it chooses one chunk type (RUN, INDEX, RGB or RGBA) using its own previous-pixel register, run counter and 64-entry index table. It serializes the chosen chunk onto a backpressured byte stream, then emits the 8-byte end marker. It sits between the pixel source and the byte sink and replaces ad-hoc priority muxing of per-op encoders.

---
 rtl/qoi_stream_sequencer_if.sv | 36 +++
 rtl/qoi_stream_sequencer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_qoi_stream_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qoi_stream_sequencer_if.sv
// qoi_stream_sequencer_if
//   Bundles the two handshakes around the QOI frame sequencer:
//     pixel / pixel_valid / pixel_ready      : pixel source -> sequencer
//     ostream / ostream_valid / ostream_ready : sequencer -> byte sink
//   Modports:
//     master : the sequencer side (accepts pixels, drives the byte stream)
//     slave  : the environment side (supplies pixels, sinks bytes)
//   COMPONENTS sets the pixel width (3 = RGB, 4 = RGBA, 8 bits each).
interface qoi_stream_sequencer_if #(
  parameter int COMPONENTS = 4
);
  logic [8*COMPONENTS-1:0] pixel;
  logic                    pixel_valid;
  logic                    pixel_ready;
  logic [7:0]              ostream;
  logic                    ostream_valid;
  logic                    ostream_ready;

  modport master (
    input  pixel,
    input  pixel_valid,
    output pixel_ready,
    output ostream,
    output ostream_valid,
    input  ostream_ready
  );

  modport slave (
    output pixel,
    output pixel_valid,
    input  pixel_ready,
    input  ostream,
    input  ostream_valid,
    output ostream_ready
  );
endinterface

// File: rtl/qoi_stream_sequencer.sv
// qoi_stream_sequencer
//   Frame-level QOI encoder controller. On start it emits the 14-byte QOI
//   header, then accepts one pixel per handshake and picks a single chunk
//   (RUN, INDEX, RGB or RGBA) from its previous-pixel register, run counter
//   and 64-entry colour index. The chosen chunk is serialized onto a
//   backpressured byte stream; after the last pixel the 8-byte end marker
//   follows and done pulses.
//
//   Ports:
//     clk         clock
//     rst_n       synchronous active-low reset
//     start       begin a frame (only honoured while idle)
//     width       image width, captured on start
//     height      image height, captured on start
//     colorspace  header colorspace byte value, captured on start
//     bus         pixel and byte-stream handshakes (master modport)
//     busy        high from the cycle after start until the frame finishes
//     done        one-cycle pulse after the final end-marker byte is taken
//
//   All outputs are registered. The byte stream holds steady while stalled
//   and presents a new byte the cycle after each accepted byte.
module qoi_stream_sequencer #(
  parameter int COMPONENTS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            width,
  input  logic [15:0]            height,
  input  logic                   colorspace,
  qoi_stream_sequencer_if.master bus,
  output logic                   busy,
  output logic                   done
);

  localparam logic [31:0] PREV_INIT  = 32'h0000_00FF;
  localparam logic [3:0]  HDR_LEN    = 4'd14;
  localparam logic [3:0]  TRL_LEN    = 4'd8;
  localparam logic [5:0]  RUN_MAX    = 6'd62;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PIXEL,
    S_EMIT,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  idx;          // next header/trailer byte to present
  logic [15:0] w_q;
  logic [15:0] h_q;
  logic        cs_q;
  logic [31:0] total;
  logic [31:0] pix_cnt;
  logic [31:0] prev;
  logic [5:0]  run;
  logic [63:0] valid_bits;
  logic [31:0] tbl [64];
  logic [39:0] cbuf;         // chunk bytes still to send, MSB first
  logic [2:0]  crem;         // number of bytes left in cbuf

  // Pixel normalised to RGBA; RGB images carry an implicit opaque alpha.
  logic [31:0] px;

  if (COMPONENTS == 4) begin : g_rgba
    assign px = bus.pixel;
  end else begin : g_rgb
    assign px = {bus.pixel, 8'hFF};
  end

  // QOI colour hash. Only the low 6 bits matter, so 11-bit sums are enough.
  function automatic logic [5:0] qoi_hash(input logic [31:0] p);
    logic [10:0] s;
    s = 11'(p[31:24]) * 11'd3
      + 11'(p[23:16]) * 11'd5
      + 11'(p[15:8])  * 11'd7
      + 11'(p[7:0])   * 11'd11;
    return s[5:0];
  endfunction

  // Header: magic "qoif", width and height as 32-bit big-endian,
  // channel count, colorspace.
  function automatic logic [7:0] hdr_byte(input logic [3:0]  i,
                                          input logic [15:0] w,
                                          input logic [15:0] h,
                                          input logic        cs);
    logic [7:0] b;
    case (i)
      4'd0:    b = 8'h71;
      4'd1:    b = 8'h6F;
      4'd2:    b = 8'h69;
      4'd3:    b = 8'h66;
      4'd6:    b = w[15:8];
      4'd7:    b = w[7:0];
      4'd10:   b = h[15:8];
      4'd11:   b = h[7:0];
      4'd12:   b = 8'(COMPONENTS);
      4'd13:   b = {7'd0, cs};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // End marker: seven zero bytes followed by 0x01.
  function automatic logic [7:0] trl_byte(input logic [3:0] i);
    return (i == 4'd7) ? 8'h01 : 8'h00;
  endfunction

  logic        px_hs;
  logic        os_hs;
  logic [5:0]  hash;
  logic [31:0] entry;
  logic        same;
  logic [5:0]  run_inc;
  logic        last_px;
  logic        flush;
  logic [39:0] pc;
  logic [2:0]  pc_len;
  logic [47:0] chunk;
  logic [2:0]  chunk_len;

  assign px_hs = bus.pixel_valid && bus.pixel_ready;
  assign os_hs = bus.ostream_valid && bus.ostream_ready;

  // Chunk selection for the pixel currently offered.
  always_comb begin
    hash    = qoi_hash(px);
    // An entry never written reads as transparent black.
    entry   = valid_bits[hash] ? tbl[hash] : 32'h0;
    same    = (px == prev);
    run_inc = run + 6'd1;
    last_px = ((pix_cnt + 32'd1) == total);
    flush   = same && ((run_inc == RUN_MAX) || last_px);

    if (entry == px) begin
      pc     = {2'b00, hash, 32'h0};
      pc_len = 3'd1;
    end else if (px[7:0] == prev[7:0]) begin
      pc     = {8'hFE, px[31:8], 8'h00};
      pc_len = 3'd4;
    end else begin
      pc     = {8'hFF, px};
      pc_len = 3'd5;
    end

    if (same) begin
      // Flushing run: length run_inc encoded as bias-1, i.e. the old run.
      chunk     = {2'b11, run, 40'h0};
      chunk_len = 3'd1;
    end else if (run != 6'd0) begin
      // A pending run goes out ahead of the pixel's own chunk.
      chunk     = {2'b11, run - 6'd1, pc};
      chunk_len = pc_len + 3'd1;
    end else begin
      chunk     = {pc, 8'h00};
      chunk_len = pc_len;
    end
  end

  // Index table contents are plain data; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (state == S_PIXEL && px_hs && !same) begin
      tbl[hash] <= px;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      idx               <= 4'd0;
      w_q               <= 16'd0;
      h_q               <= 16'd0;
      cs_q              <= 1'b0;
      total             <= 32'd0;
      pix_cnt           <= 32'd0;
      prev              <= PREV_INIT;
      run               <= 6'd0;
      valid_bits        <= 64'd0;
      cbuf              <= 40'd0;
      crem              <= 3'd0;
      bus.pixel_ready   <= 1'b0;
      bus.ostream       <= 8'h00;
      bus.ostream_valid <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            w_q               <= width;
            h_q               <= height;
            cs_q              <= colorspace;
            total             <= 32'(width) * 32'(height);
            pix_cnt           <= 32'd0;
            prev              <= PREV_INIT;
            run               <= 6'd0;
            valid_bits        <= 64'd0;
            // First magic byte goes out immediately.
            bus.ostream       <= 8'h71;
            bus.ostream_valid <= 1'b1;
            idx               <= 4'd1;
            busy              <= 1'b1;
            state             <= S_HEADER;
          end
        end

        S_HEADER: begin
          if (os_hs) begin
            if (idx == HDR_LEN) begin
              if (total == 32'd0) begin
                bus.ostream       <= trl_byte(4'd0);
                bus.ostream_valid <= 1'b1;
                idx               <= 4'd1;
                state             <= S_TRAILER;
              end else begin
                bus.ostream_valid <= 1'b0;
                bus.pixel_ready   <= 1'b1;
                state             <= S_PIXEL;
              end
            end else begin
              bus.ostream <= hdr_byte(idx, w_q, h_q, cs_q);
              idx         <= idx + 4'd1;
            end
          end
        end

        S_PIXEL: begin
          if (px_hs) begin
            pix_cnt <= pix_cnt + 32'd1;
            if (same && !flush) begin
              // Run continues silently; stay ready for the next pixel.
              run <= run_inc;
            end else begin
              if (!same) begin
                prev             <= px;
                valid_bits[hash] <= 1'b1;
              end
              run               <= 6'd0;
              bus.ostream       <= chunk[47:40];
              bus.ostream_valid <= 1'b1;
              bus.pixel_ready   <= 1'b0;
              cbuf              <= chunk[39:0];
              crem              <= chunk_len - 3'd1;
              state             <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          if (os_hs) begin
            if (crem != 3'd0) begin
              bus.ostream <= cbuf[39:32];
              cbuf        <= {cbuf[31:0], 8'h00};
              crem        <= crem - 3'd1;
            end else if (pix_cnt == total) begin
              bus.ostream       <= trl_byte(4'd0);
              idx               <= 4'd1;
              state             <= S_TRAILER;
            end else begin
              bus.ostream_valid <= 1'b0;
              bus.pixel_ready   <= 1'b1;
              state             <= S_PIXEL;
            end
          end
        end

        S_TRAILER: begin
          if (os_hs) begin
            if (idx == TRL_LEN) begin
              bus.ostream_valid <= 1'b0;
              busy              <= 1'b0;
              done              <= 1'b1;
              state             <= S_DONE;
            end else begin
              bus.ostream <= trl_byte(idx);
              idx         <= idx + 4'd1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qoi_stream_sequencer.sv
`timescale 1ns/1ps
module tb_qoi_stream_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start4, start3;
  logic [15:0] width, height;
  logic        colorspace;
  logic        busy4, done4, busy3, done3;
  logic        ordy;

  qoi_stream_sequencer_if #(.COMPONENTS(4)) bus4 ();
  qoi_stream_sequencer_if #(.COMPONENTS(3)) bus3 ();

  assign bus4.ostream_ready = ordy;
  assign bus3.ostream_ready = ordy;

  qoi_stream_sequencer #(.COMPONENTS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .width(width), .height(height),
    .colorspace(colorspace), .bus(bus4), .busy(busy4), .done(done4)
  );

  qoi_stream_sequencer #(.COMPONENTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .width(width), .height(height),
    .colorspace(colorspace), .bus(bus3), .busy(busy3), .done(done3)
  );

  int n_err = 0;
  int n_chk = 0;

  logic [7:0]  exp4[$], exp3[$], cap4[$], cap3[$], model_q[$], lit[$];
  logic [31:0] frame_px[$];
  int          done_cnt4 = 0, done_cnt3 = 0;
  bit          stall_en = 1'b0;
  bit          st4 = 1'b0, st3 = 1'b0;
  logic [7:0]  sb4, sb3;

  localparam logic [31:0] PA = 32'h10203040;
  localparam logic [31:0] PB = 32'h01020304;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Reference encoder: straight from the QOI chunk rules.
  function automatic void model_encode(input int comps, input int w, input int h, input int cs);
    logic [31:0] tbl[64];
    logic [31:0] prv, p;
    int run, total, hh;
    model_q.delete();
    model_q.push_back(8'h71); model_q.push_back(8'h6F);
    model_q.push_back(8'h69); model_q.push_back(8'h66);
    model_q.push_back(8'h00); model_q.push_back(8'h00);
    model_q.push_back(8'(w / 256)); model_q.push_back(8'(w % 256));
    model_q.push_back(8'h00); model_q.push_back(8'h00);
    model_q.push_back(8'(h / 256)); model_q.push_back(8'(h % 256));
    model_q.push_back(8'(comps)); model_q.push_back(8'(cs));
    for (int i = 0; i < 64; i++) tbl[i] = 32'h0;
    prv = 32'h000000FF;
    run = 0;
    total = w * h;
    for (int i = 0; i < total; i++) begin
      p = frame_px[i];
      if (p == prv) begin
        run++;
        if (run == 62 || i == total - 1) begin
          model_q.push_back(8'(192 + run - 1));
          run = 0;
        end
      end else begin
        if (run > 0) begin
          model_q.push_back(8'(192 + run - 1));
          run = 0;
        end
        hh = (int'(p[31:24]) * 3 + int'(p[23:16]) * 5 + int'(p[15:8]) * 7 + int'(p[7:0]) * 11) % 64;
        if (tbl[hh] == p) begin
          model_q.push_back(8'(hh));
        end else if (p[7:0] == prv[7:0]) begin
          model_q.push_back(8'hFE); model_q.push_back(p[31:24]);
          model_q.push_back(p[23:16]); model_q.push_back(p[15:8]);
        end else begin
          model_q.push_back(8'hFF); model_q.push_back(p[31:24]);
          model_q.push_back(p[23:16]); model_q.push_back(p[15:8]);
          model_q.push_back(p[7:0]);
        end
        tbl[hh] = p;
        prv = p;
      end
    end
    for (int i = 0; i < 7; i++) model_q.push_back(8'h00);
    model_q.push_back(8'h01);
  endfunction

  // Output ready: steady high, or random stalls when enabled.
  initial begin
    ordy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ordy = stall_en ? ($urandom_range(0, 4) >= 2) : 1'b1;
    end
  end

  // Per-cycle comparison of both byte streams against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st4 = 1'b0;
        st3 = 1'b0;
      end else begin
        if (st4) begin
          chk("hold_valid4", 32'(bus4.ostream_valid), 32'd1);
          chk("hold_byte4", 32'(bus4.ostream), 32'(sb4));
        end
        if (bus4.ostream_valid && bus4.ostream_ready) begin
          cap4.push_back(bus4.ostream);
          if (exp4.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL extra_byte4: got %h, expected no byte", bus4.ostream);
          end else begin
            chk("byte4", 32'(bus4.ostream), 32'(exp4.pop_front()));
          end
        end
        if (bus4.ostream_valid) chk("excl4", 32'(bus4.pixel_ready), 32'd0);
        if (done4) begin
          done_cnt4++;
          chk("done_busy4", 32'(busy4), 32'd0);
        end
        st4 = bus4.ostream_valid && !bus4.ostream_ready;
        sb4 = bus4.ostream;

        if (st3) begin
          chk("hold_valid3", 32'(bus3.ostream_valid), 32'd1);
          chk("hold_byte3", 32'(bus3.ostream), 32'(sb3));
        end
        if (bus3.ostream_valid && bus3.ostream_ready) begin
          cap3.push_back(bus3.ostream);
          if (exp3.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL extra_byte3: got %h, expected no byte", bus3.ostream);
          end else begin
            chk("byte3", 32'(bus3.ostream), 32'(exp3.pop_front()));
          end
        end
        if (bus3.ostream_valid) chk("excl3", 32'(bus3.pixel_ready), 32'd0);
        if (done3) begin
          done_cnt3++;
          chk("done_busy3", 32'(busy3), 32'd0);
        end
        st3 = bus3.ostream_valid && !bus3.ostream_ready;
        sb3 = bus3.ostream;
      end
    end
  end

  task automatic drive_px(input int sel, input bit v, input logic [31:0] p);
    if (sel == 0) begin
      bus4.pixel_valid = v;
      bus4.pixel = p;
    end else begin
      bus3.pixel_valid = v;
      bus3.pixel = p[31:8];
    end
  endtask

  task automatic run_frame(input int sel, input int w, input int h, input int cs,
                           input bit stall, input bit poke);
    int n, idx, guard;
    bit v, hs;
    logic rdy;
    n = w * h;
    model_encode((sel == 0) ? 4 : 3, w, h, cs);
    if (sel == 0) begin
      exp4 = model_q; cap4.delete(); done_cnt4 = 0;
    end else begin
      exp3 = model_q; cap3.delete(); done_cnt3 = 0;
    end
    stall_en = stall;
    width = 16'(w);
    height = 16'(h);
    colorspace = cs[0];
    if (sel == 0) start4 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start3 = 1'b0;
    // Inputs captured on start must not matter afterwards.
    width = 16'hABCD; height = 16'h1234; colorspace = ~cs[0];
    chk("busy_rise", 32'((sel == 0) ? busy4 : busy3), 32'd1);
    chk("hdr0_valid", 32'((sel == 0) ? bus4.ostream_valid : bus3.ostream_valid), 32'd1);
    chk("hdr0_byte", 32'((sel == 0) ? bus4.ostream : bus3.ostream), 32'h71);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 20000) begin
      v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_px(sel, v, frame_px[idx]);
      if (poke && idx == 1) begin
        if (sel == 0) start4 = 1'b1; else start3 = 1'b1;
      end
      rdy = (sel == 0) ? bus4.pixel_ready : bus3.pixel_ready;
      hs = v && rdy;
      @(posedge clk); #1;
      start4 = 1'b0; start3 = 1'b0;
      if (hs) idx++;
      guard++;
    end
    drive_px(sel, 1'b0, 32'h0);
    if (guard >= 20000) fail_now("pixel_feed_timeout");
    guard = 0;
    while (((sel == 0) ? busy4 : busy3) && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20000) fail_now("frame_end_timeout");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_pulses", 32'((sel == 0) ? done_cnt4 : done_cnt3), 32'd1);
    chk("bytes_left", 32'((sel == 0) ? exp4.size() : exp3.size()), 32'd0);
    stall_en = 1'b0;
  endtask

  task automatic lp(input logic [7:0] b);
    lit.push_back(b);
  endtask

  task automatic lit_hdr(input logic [7:0] w, input logic [7:0] h, input logic [7:0] ch, input logic [7:0] cs);
    lit.delete();
    lp(8'h71); lp(8'h6F); lp(8'h69); lp(8'h66);
    lp(8'h00); lp(8'h00); lp(8'h00); lp(w);
    lp(8'h00); lp(8'h00); lp(8'h00); lp(h);
    lp(ch); lp(cs);
  endtask

  task automatic lit_trl();
    for (int i = 0; i < 7; i++) lp(8'h00);
    lp(8'h01);
  endtask

  task automatic chk_lit(input string name, input int sel);
    int sz, bad;
    logic [7:0] c;
    sz = (sel == 0) ? cap4.size() : cap3.size();
    chk({name, "_len"}, 32'(sz), 32'(lit.size()));
    bad = 0;
    for (int i = 0; i < lit.size() && i < sz; i++) begin
      c = (sel == 0) ? cap4[i] : cap3[i];
      if (c !== lit[i] && bad == 0) begin
        bad = 1;
        chk({name, "_byte"}, 32'(c), 32'(lit[i]));
      end
    end
    if (bad == 0) chk({name, "_bytes"}, 32'(sz), 32'(lit.size()));
  endtask

  task automatic gen_random(input int n, input int comps);
    logic [31:0] pal[4];
    logic [31:0] p, last;
    pal[0] = 32'h0;
    for (int i = 1; i < 4; i++) begin
      pal[i] = $urandom;
      if ($urandom_range(0, 1) == 0) pal[i][7:0] = 8'hFF;
    end
    frame_px.delete();
    last = 32'h000000FF;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) p = last;
      else if ($urandom_range(0, 5) == 0) p = $urandom;
      else p = pal[$urandom_range(0, 3)];
      if (comps == 3) p[7:0] = 8'hFF;
      frame_px.push_back(p);
      last = p;
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    start4 = 1'b0; start3 = 1'b0;
    width = 16'd0; height = 16'd0; colorspace = 1'b0;
    bus4.pixel = 32'h0; bus4.pixel_valid = 1'b0;
    bus3.pixel = 24'h0; bus3.pixel_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pixel_ready", 32'(bus4.pixel_ready), 32'd0);
    chk("rst_ostream", 32'(bus4.ostream), 32'd0);
    chk("rst_ostream_valid", 32'(bus4.ostream_valid), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst3_ostream_valid", 32'(bus3.ostream_valid), 32'd0);
    chk("rst3_busy", 32'(busy3), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8x8 single colour equal to the initial previous pixel.
    frame_px.delete();
    for (int i = 0; i < 64; i++) frame_px.push_back(32'h000000FF);
    run_frame(0, 8, 8, 0, 1'b0, 1'b0);
    lit_hdr(8'h08, 8'h08, 8'h04, 8'h00); lp(8'hFD); lp(8'hC1); lit_trl();
    chk_lit("flat8x8", 0);

    // A, B, A: two RGBA chunks then an index hit on hash 32.
    frame_px.delete();
    frame_px.push_back(PA); frame_px.push_back(PB); frame_px.push_back(PA);
    model_encode(4, 3, 1, 0);
    chk("model_aba_len", 32'(model_q.size()), 32'd33);
    chk("model_aba_index", 32'(model_q[24]), 32'h20);
    run_frame(0, 3, 1, 0, 1'b0, 1'b0);
    lit_hdr(8'h03, 8'h01, 8'h04, 8'h00);
    lp(8'hFF); lp(8'h10); lp(8'h20); lp(8'h30); lp(8'h40);
    lp(8'hFF); lp(8'h01); lp(8'h02); lp(8'h03); lp(8'h04);
    lp(8'h20); lit_trl();
    chk_lit("aba", 0);

    // Same frame under random backpressure: identical stream.
    run_frame(0, 3, 1, 0, 1'b1, 1'b0);
    chk_lit("aba_stall", 0);

    // RGB chunks, colorspace 1.
    frame_px.delete();
    frame_px.push_back(32'h112233FF); frame_px.push_back(32'h445566FF);
    run_frame(0, 2, 1, 1, 1'b0, 1'b0);
    lit_hdr(8'h02, 8'h01, 8'h04, 8'h01);
    lp(8'hFE); lp(8'h11); lp(8'h22); lp(8'h33);
    lp(8'hFE); lp(8'h44); lp(8'h55); lp(8'h66); lit_trl();
    chk_lit("rgb", 0);

    // Three-component image: run of 3 then an RGB chunk.
    frame_px.delete();
    for (int i = 0; i < 3; i++) frame_px.push_back(32'h000000FF);
    frame_px.push_back(32'h0A0B0CFF);
    run_frame(1, 4, 1, 0, 1'b0, 1'b0);
    lit_hdr(8'h04, 8'h01, 8'h03, 8'h00);
    lp(8'hC2); lp(8'hFE); lp(8'h0A); lp(8'h0B); lp(8'h0C); lit_trl();
    chk_lit("run_rgb3", 1);

    // Long single-colour run crossing the 62 limit, stalled.
    frame_px.delete();
    for (int i = 0; i < 140; i++) frame_px.push_back(32'h55667788);
    run_frame(0, 10, 14, 0, 1'b1, 1'b0);

    // Randomized frames on both widths; one pokes start mid-frame.
    for (int f = 0; f < 6; f++) begin
      int w, h;
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 8);
      gen_random(w * h, 4);
      run_frame(0, w, h, f % 2, f[0], f == 2);
    end
    for (int f = 0; f < 3; f++) begin
      int w, h;
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 8);
      gen_random(w * h, 3);
      run_frame(1, w, h, f % 2, f[0], f == 1);
    end

    // Reset while an RGBA chunk is mid-emission.
    frame_px.delete();
    frame_px.push_back(PA); frame_px.push_back(PB); frame_px.push_back(PA);
    model_encode(4, 3, 1, 0);
    exp4 = model_q;
    width = 16'd3; height = 16'd1; colorspace = 1'b0;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    drive_px(0, 1'b1, PA);
    guard = 0;
    while (!bus4.pixel_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) fail_now("reset_test_ready");
    @(posedge clk); #1;
    drive_px(0, 1'b0, 32'h0);
    chk("emit_first_byte", 32'(bus4.ostream), 32'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_pixel_ready", 32'(bus4.pixel_ready), 32'd0);
    chk("mid_rst_ostream", 32'(bus4.ostream), 32'd0);
    chk("mid_rst_ostream_valid", 32'(bus4.ostream_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy4), 32'd0);
    chk("mid_rst_done", 32'(done4), 32'd0);
    exp4.delete();
    @(posedge clk); #1;

    // Zero-size frame: header then trailer only.
    frame_px.delete();
    run_frame(0, 0, 5, 0, 1'b0, 1'b0);
    lit_hdr(8'h00, 8'h05, 8'h04, 8'h00); lit_trl();
    chk_lit("zero_size", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
